// File: rtl/loader_pkg.sv
// Shared types and sizing constants for the boot-time instruction loader.
// Stream framing: 2 header bytes (word count, little-endian), then 4 bytes per word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes LS-first into a 32-bit word; o_word_ready pulses (combinationally)
// with the 4th pushed byte, and o_word carries the complete word in that same cycle.
module word_assembler
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic        w_last_byte;

    assign w_last_byte  = (r_cnt == 2'(WORD_BYTES - 1));
    assign o_word_ready = i_push && w_last_byte;
    assign o_word       = {i_byte, r_shift};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_push) begin
            // Newest byte enters at the top so the first byte ends up least significant.
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core until it completes.
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int HDR_BITS = 8 * HDR_BYTES;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e S_TAIL = CHK;
`else
    localparam loader_state_e S_TAIL = DONE;
`endif

    loader_state_e       r_state;
    loader_state_e       w_state_nxt;
    logic [HDR_BITS-1:0] r_n;
    logic [15:0]         r_idx;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic                w_hs;
    logic                w_arm;
    logic                w_push;
    logic                w_last;
    logic [HDR_BITS-1:0] w_n_full;
    logic                w_n_big;
    logic [31:0]         w_word;
    logic                w_word_ready;

    assign byte_ready = (r_state == HDR_LO) || (r_state == HDR_HI) ||
                        (r_state == DATA)   || (r_state == CHK);
    assign w_hs       = byte_valid && byte_ready;
    assign w_push     = (r_state == DATA) && w_hs;
    assign w_n_full   = {byte_data, r_n[7:0]};
    assign w_n_big    = ({16'd0, w_n_full} > 32'(MAX_WORDS));
    assign w_last     = (({1'b0, r_idx} + 17'd1) == {1'b0, r_n});

    word_assembler u_asm (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_clr        (w_arm),
        .i_push       (w_push),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sum <= '0;
        end else if (w_arm) begin
            r_sum <= '0;
        end else if (w_push) begin
            r_sum <= r_sum + byte_data;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_arm       = 1'b1;
                    w_state_nxt = HDR_LO;
                end
            end
            HDR_LO: begin
                if (w_hs) w_state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (w_hs) begin
                    if (w_n_big)                w_state_nxt = ERR;
                    else if (w_n_full == '0)    w_state_nxt = S_TAIL;
                    else                        w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_push && w_word_ready) w_state_nxt = WRITE;
            end
            WRITE: begin
                w_state_nxt = w_last ? S_TAIL : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (w_hs) w_state_nxt = (byte_data == r_sum) ? DONE : ERR;
            end
`endif
            default: w_state_nxt = ERR;
        endcase
    end

    // Address and data are captured with the completing byte so they stay put outside WRITE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_n     <= '0;
            r_idx   <= '0;
            r_waddr <= BASE_ADDR;
            r_wdata <= '0;
        end else begin
            if (w_arm) r_idx <= '0;
            if (r_state == HDR_LO && w_hs) r_n[7:0]  <= byte_data;
            if (r_state == HDR_HI && w_hs) r_n[15:8] <= byte_data;
            if (w_push && w_word_ready) begin
                r_wdata <= w_word;
                r_waddr <= BASE_ADDR + ADDR_W'({r_idx, 2'b00});
            end
            if (r_state == WRITE) r_idx <= r_idx + 16'd1;
        end
    end

    assign mem_wr    = (r_state == WRITE);
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;
    assign cpu_hold  = (r_state != DONE);
    assign done      = (r_state == DONE);
    assign err       = (r_state == ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed and randomized images checked against a queue-based image model.
// Checksum byte is appended when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr;
    logic [63:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  img[$];
    logic [31:0] words[$];
    logic [31:0] exp_w[$];
    logic        exp_err;
    logic [63:0] got_a[$];
    logic [31:0] got_d[$];

    always #5 CLK = ~CLK;

    instr_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_wr     (mem_wr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_wr === 1'b1) begin
            got_a.push_back(mem_waddr);
            got_d.push_back(mem_wdata);
            chk("ready_in_write", {63'd0, byte_ready}, 64'd0);
        end
    end

    task automatic check_reset_vals();
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_mem_wr",     {63'd0, mem_wr},     64'd0);
        chk("rst_mem_waddr",  mem_waddr,           64'd0);
        chk("rst_mem_wdata",  {32'd0, mem_wdata},  64'd0);
        chk("rst_cpu_hold",   {63'd0, cpu_hold},   64'd1);
        chk("rst_done",       {63'd0, done},       64'd0);
        chk("rst_err",        {63'd0, err},        64'd0);
    endtask

    // Image model: header, LE words, optional checksum (sum of data bytes + delta).
    task automatic make_image(input int n_hdr, input logic [7:0] ck_delta);
        logic [7:0]  sum = 8'd0;
        logic [15:0] n16 = n_hdr[15:0];
        logic [31:0] w;
        img.delete();
        exp_w.delete();
        img.push_back(n16[7:0]);
        img.push_back(n16[15:8]);
        exp_err = (n_hdr > 4096);
        if (!exp_err) begin
            foreach (words[i]) begin
                w = words[i];
                exp_w.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    img.push_back(w[8*k +: 8]);
                    sum = sum + w[8*k +: 8];
                end
            end
`ifdef LOADER_CHECKSUM_EN
            img.push_back(sum + ck_delta);
            exp_err = (ck_delta != 8'd0);
`endif
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge CLK);
            if (byte_ready) break;
            t++;
            if (t > 200) begin
                chk("byte_accept_timeout", 64'(t), 64'd0);
                break;
            end
        end
        @(posedge CLK); #1;
        byte_valid = 1'b0;
    endtask

    task automatic stream(input int gapmax, input int start_at, input bit do_start, input int upto);
        int g;
        if (do_start) pulse_start();
        for (int i = 0; i < img.size() && i < upto; i++) begin
            if (i == start_at) pulse_start();
            g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            repeat (g) begin @(posedge CLK); #1; end
            send_byte(img[i]);
        end
    endtask

    task automatic finish_check(input string tag);
        int t = 0;
        while (!(done || err) && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk({tag, "_terminated"}, {63'd0, done || err}, 64'd1);
        chk({tag, "_done"},     {63'd0, done},       {63'd0, !exp_err});
        chk({tag, "_err"},      {63'd0, err},        {63'd0, exp_err});
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold},   {63'd0, exp_err});
        chk({tag, "_ready"},    {63'd0, byte_ready}, 64'd0);
        chk({tag, "_nwrites"},  64'(got_a.size()),   64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_a.size(); i++) begin
            if (got_a[i] !== 64'(4 * i) || got_d[i] !== exp_w[i]) begin
                chk({tag, "_waddr"}, got_a[i], 64'(4 * i));
                chk({tag, "_wdata"}, {32'd0, got_d[i]}, {32'd0, exp_w[i]});
            end else begin
                n_tests++;
            end
        end
        got_a.delete();
        got_d.delete();
    endtask

    task automatic set_test1();
        words.delete();
        words.push_back(32'h0000_0013);
        words.push_back(32'h0010_0093);
    endtask

    task automatic set_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    initial begin
        RST        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        #2;
        check_reset_vals();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        // basic two-word image
        set_test1();
        make_image(2, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("t1");

        // oversize header
        words.delete();
        make_image(32'h1001, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("t2_oversize");
        make_image(32'hFFFF, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("t2_ffff");

        // random valid gaps
        for (int r = 0; r < 3; r++) begin
            set_test1();
            make_image(2, 8'd0);
            stream(7, -1, 1, 1 << 30);
            finish_check("t3_gaps");
        end

        // reset after 5 data bytes, then fresh load
        set_test1();
        make_image(2, 8'd0);
        stream(0, -1, 1, 7);
        RST = 1'b0;
        #2;
        check_reset_vals();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        got_a.delete();
        got_d.delete();
        stream(2, -1, 1, 1 << 30);
        finish_check("t4_after_rst");

        // start during DATA ignored
        set_test1();
        make_image(2, 8'd0);
        stream(2, 4, 1, 1 << 30);
        finish_check("t6_start_busy");

        // start in DONE re-arms next cycle
        pulse_start();
        chk("t6_rearm_hold",  {63'd0, cpu_hold},   64'd1);
        chk("t6_rearm_ready", {63'd0, byte_ready}, 64'd1);
        chk("t6_rearm_done",  {63'd0, done},       64'd0);
        set_random(3);
        make_image(3, 8'd0);
        stream(1, -1, 0, 1 << 30);
        finish_check("t6_rearm_load");

        // checksum mismatch (only errs when checksum is compiled in)
        set_test1();
        make_image(2, 8'hFF);
        stream(0, -1, 1, 1 << 30);
        finish_check("t5_cksum");

        // empty image and maximum image
        words.delete();
        make_image(0, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("n0");
        set_random(4096);
        make_image(4096, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("n4096");
        set_random(1);
        make_image(4097, 8'd0);
        stream(0, -1, 1, 1 << 30);
        finish_check("n4097");

        // randomized images
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(8, 1);
            set_random(n);
            make_image(n, ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0);
            stream(3, -1, 1, 1 << 30);
            finish_check("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
